// File: rtl/out_fifo_pkg.sv
// out_fifo_pkg: shared constants for the transmit-side output FIFO.
//   MODE_8X4 / MODE_4X4 : internal read-mode encoding
//   BYTE_W / NIB_W      : write-lane and read-lane widths
//   cnt_width()         : occupancy counter width for a given depth (0..DEPTH)
package out_fifo_pkg;

  localparam logic MODE_8X4 = 1'b1;
  localparam logic MODE_4X4 = 1'b0;

  localparam int BYTE_W = 8;
  localparam int NIB_W  = 4;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/out_fifo_flags.sv
// out_fifo_flags: registers the four status flags from the next-cycle
// occupancy so they are valid right after the edge that changes the count.
//   i_clk        clock
//   i_rst        asynchronous active-high reset
//   i_count      next-cycle occupancy (entries not fully retired)
//   o_empty      occupancy == 0
//   o_full       occupancy == DEPTH
//   o_almost_empty  occupancy <= ALMOST_EMPTY_VALUE
//   o_almost_full   free entries <= ALMOST_FULL_VALUE
module out_fifo_flags
  import out_fifo_pkg::*;
#(
  parameter int DEPTH              = 8,
  parameter int ALMOST_EMPTY_VALUE = 1,
  parameter int ALMOST_FULL_VALUE  = 1,
  parameter int CW                 = cnt_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [CW-1:0] i_count,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_almost_empty,
  output logic          o_almost_full
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AE_TH   = CW'(ALMOST_EMPTY_VALUE);
  // DEPTH - count <= AF  <=>  count >= DEPTH - AF
  localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - ALMOST_FULL_VALUE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_empty        <= 1'b1;
      o_full         <= 1'b0;
      o_almost_empty <= 1'b1;
      o_almost_full  <= 1'b0;
    end else begin
      o_empty        <= (i_count == '0);
      o_full         <= (i_count == DEPTH_C);
      o_almost_empty <= (i_count <= AE_TH);
      o_almost_full  <= (i_count >= AF_TH);
    end
  end

endmodule

// File: rtl/out_fifo_sync.sv
// out_fifo_sync: single-clock output FIFO, NUM_CH byte lanes written in
// parallel, drained one nibble per lane per read.
//   ARRAY_MODE_8_X_4 : each word is read as low nibble then high nibble
//   ARRAY_MODE_4_X_4 : each word is read once as its low nibble
// Ports:
//   RDCLK, RESET (async, active-high)
//   WREN, D[NUM_CH*8]   write side; FULL, ALMOSTFULL
//   RDEN, Q[NUM_CH*4]   read side (Q registered); EMPTY, ALMOSTEMPTY
//   OVERFLOW, UNDERFLOW sticky error flags, only when the macro
//                       OUT_FIFO_SYNC_ERRFLAG_EN is defined
module out_fifo_sync
  import out_fifo_pkg::*;
#(
  parameter int    NUM_CH             = 10,
  parameter int    DEPTH              = 8,
  parameter int    ALMOST_EMPTY_VALUE = 1,
  parameter int    ALMOST_FULL_VALUE  = 1,
  parameter string ARRAY_MODE         = "ARRAY_MODE_8_X_4"
) (
  input  logic                     RDCLK,
  input  logic                     RESET,
  input  logic                     WREN,
  input  logic [NUM_CH*BYTE_W-1:0] D,
  output logic                     FULL,
  output logic                     ALMOSTFULL,
  input  logic                     RDEN,
  output logic [NUM_CH*NIB_W-1:0]  Q,
`ifdef OUT_FIFO_SYNC_ERRFLAG_EN
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW,
`endif
  output logic                     EMPTY,
  output logic                     ALMOSTEMPTY
);

  localparam int   AW   = $clog2(DEPTH);
  localparam int   CW   = cnt_width(DEPTH);
  localparam logic MODE = (ARRAY_MODE == "ARRAY_MODE_4_X_4") ? MODE_4X4 : MODE_8X4;

  generate
    if (ARRAY_MODE != "ARRAY_MODE_8_X_4" && ARRAY_MODE != "ARRAY_MODE_4_X_4") begin : g_bad_mode
      $error("out_fifo_sync: illegal ARRAY_MODE");
    end
  endgenerate

  logic [NUM_CH*BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic                     r_nib_sel;
  logic [CW-1:0]            r_count;
  logic [NUM_CH*NIB_W-1:0]  r_q;

  logic                     w_wr_acc;
  logic                     w_rd_acc;
  logic                     w_retire;
  logic                     w_hi;
  logic [CW-1:0]            w_count_next;
  logic [NUM_CH*BYTE_W-1:0] w_rd_word;
  logic [NUM_CH*NIB_W-1:0]  w_nib;

  // FULL/EMPTY are the registered flags, so acceptance uses pre-edge state.
  assign w_wr_acc  = WREN && !FULL;
  assign w_rd_acc  = RDEN && !EMPTY;
  assign w_hi      = (MODE == MODE_8X4) && r_nib_sel;
  assign w_retire  = w_rd_acc && ((MODE == MODE_4X4) || r_nib_sel);
  assign w_rd_word = r_mem[r_rd_ptr];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      assign w_nib[gi*NIB_W +: NIB_W] = w_hi ? w_rd_word[gi*BYTE_W+NIB_W +: NIB_W]
                                             : w_rd_word[gi*BYTE_W +: NIB_W];
    end
  endgenerate

  always_comb begin
    w_count_next = r_count;
    if (w_wr_acc && !w_retire) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_wr_acc && w_retire) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Storage is deliberately left out of reset so it maps onto RAM.
  always_ff @(posedge RDCLK) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= D;
    end
  end

  always_ff @(posedge RDCLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_nib_sel <= 1'b0;
      r_count   <= '0;
      r_q       <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_q <= w_nib;
        if (MODE == MODE_8X4) begin
          r_nib_sel <= !r_nib_sel;
        end
      end
      if (w_retire) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  assign Q = r_q;

  out_fifo_flags #(
    .DEPTH              (DEPTH),
    .ALMOST_EMPTY_VALUE (ALMOST_EMPTY_VALUE),
    .ALMOST_FULL_VALUE  (ALMOST_FULL_VALUE),
    .CW                 (CW)
  ) u_flags (
    .i_clk          (RDCLK),
    .i_rst          (RESET),
    .i_count        (w_count_next),
    .o_empty        (EMPTY),
    .o_full         (FULL),
    .o_almost_empty (ALMOSTEMPTY),
    .o_almost_full  (ALMOSTFULL)
  );

`ifdef OUT_FIFO_SYNC_ERRFLAG_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge RDCLK or posedge RESET) begin
    if (RESET) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (WREN && FULL)  r_overflow  <= 1'b1;
      if (RDEN && EMPTY) r_underflow <= 1'b1;
    end
  end

  assign OVERFLOW  = r_overflow;
  assign UNDERFLOW = r_underflow;
`endif

endmodule

// File: tb/tb_out_fifo_sync.sv
module tb_out_fifo_sync;

  localparam int NUM_CH = 10;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8x4 instance
  logic                  rst8, wren8, rden8;
  logic [NUM_CH*8-1:0]   d8;
  logic [NUM_CH*4-1:0]   q8;
  logic                  full8, afull8, empty8, aempty8;
  // 4x4 instance
  logic                  rst4, wren4, rden4;
  logic [NUM_CH*8-1:0]   d4;
  logic [NUM_CH*4-1:0]   q4;
  logic                  full4, afull4, empty4, aempty4;
`ifdef OUT_FIFO_SYNC_ERRFLAG_EN
  logic ovf8, unf8, ovf4, unf4;
`endif

  out_fifo_sync #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ARRAY_MODE("ARRAY_MODE_8_X_4")) u8 (
    .RDCLK(clk), .RESET(rst8), .WREN(wren8), .D(d8), .FULL(full8), .ALMOSTFULL(afull8),
    .RDEN(rden8), .Q(q8),
`ifdef OUT_FIFO_SYNC_ERRFLAG_EN
    .OVERFLOW(ovf8), .UNDERFLOW(unf8),
`endif
    .EMPTY(empty8), .ALMOSTEMPTY(aempty8));

  out_fifo_sync #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ARRAY_MODE("ARRAY_MODE_4_X_4")) u4 (
    .RDCLK(clk), .RESET(rst4), .WREN(wren4), .D(d4), .FULL(full4), .ALMOSTFULL(afull4),
    .RDEN(rden4), .Q(q4),
`ifdef OUT_FIFO_SYNC_ERRFLAG_EN
    .OVERFLOW(ovf4), .UNDERFLOW(unf4),
`endif
    .EMPTY(empty4), .ALMOSTEMPTY(aempty4));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    logic [3:0] q;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected flags derived from the expected occupancy (ALMOST_* = 1).
  task automatic chk8(input string tag, input logic [3:0] nib, input int cnt);
    logic [NUM_CH*4-1:0] exp_q;
    exp_q = {NUM_CH{nib}};
    chk({tag, " Q"},           64'(q8),      64'(exp_q));
    chk({tag, " EMPTY"},       64'(empty8),  64'(cnt == 0));
    chk({tag, " FULL"},        64'(full8),   64'(cnt == DEPTH));
    chk({tag, " ALMOSTEMPTY"}, 64'(aempty8), 64'(cnt <= 1));
    chk({tag, " ALMOSTFULL"},  64'(afull8),  64'(DEPTH - cnt <= 1));
  endtask

  task automatic step8(input logic wr, input logic rd, input logic [7:0] d);
    wren8 = wr; rden8 = rd; d8 = {NUM_CH{d}};
    @(posedge clk); #1;
    wren8 = 1'b0; rden8 = 1'b0;
  endtask

  task automatic step4(input logic wr, input logic rd, input logic [7:0] d);
    wren4 = wr; rden4 = rd; d4 = {NUM_CH{d}};
    @(posedge clk); #1;
    wren4 = 1'b0; rden4 = 1'b0;
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] d,
                              input logic [3:0] q, input int cnt);
    vec_t v;
    v.wr = wr; v.rd = rd; v.d = d; v.q = q; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    int j;
    logic [7:0] jb;
    rst8 = 1'b1; rst4 = 1'b1;
    wren8 = 0; rden8 = 0; d8 = '0;
    wren4 = 0; rden4 = 0; d4 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b0; rst4 = 1'b0;

    // ---- reset state
    chk8("reset", 4'h0, 0);
`ifdef OUT_FIFO_SYNC_ERRFLAG_EN
    chk("reset OVERFLOW",  64'(ovf8), 64'd0);
    chk("reset UNDERFLOW", 64'(unf8), 64'd0);
`endif

    // ---- 8x4 vector table
    tbl.push_back(mk(1, 0, 8'hA5, 4'h0, 1));
    tbl.push_back(mk(0, 1, 8'h00, 4'h5, 1));
    tbl.push_back(mk(0, 1, 8'h00, 4'hA, 0));
    tbl.push_back(mk(0, 1, 8'h00, 4'hA, 0));   // read on empty: Q holds
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 8'(i), 4'hA, i + 1));
    tbl.push_back(mk(1, 0, 8'h55, 4'hA, 8));   // write at FULL dropped
    for (int i = 0; i < 8; i++) begin
      j = i;
      jb = 8'(j);
      tbl.push_back(mk(0, 1, 8'h00, jb[3:0], 8 - i));
      tbl.push_back(mk(0, 1, 8'h00, 4'h0, 7 - i));
    end
    foreach (tbl[k]) begin
      step8(tbl[k].wr, tbl[k].rd, tbl[k].d);
      $display("vec %0d wr=%0b rd=%0b d=%02h q0=%0h empty=%0b full=%0b",
               k, tbl[k].wr, tbl[k].rd, tbl[k].d, q8[3:0], empty8, full8);
      chk8($sformatf("vec%0d", k), tbl[k].q, tbl[k].cnt);
    end
`ifdef OUT_FIFO_SYNC_ERRFLAG_EN
    chk("UNDERFLOW sticky", 64'(unf8), 64'd1);
    chk("OVERFLOW sticky",  64'(ovf8), 64'd1);
`endif

    // ---- FULL + WREN + second-nibble RDEN: write rejected
    for (int i = 0; i < 8; i++) step8(1, 0, 8'(8'h10 + i));
    chk8("fill2", 4'h0, 8);
    step8(0, 1, 8'h00);
    chk8("fullrd lo", 4'h0, 8);
    step8(1, 1, 8'hEE);
    $display("full wr+rd q0=%0h full=%0b", q8[3:0], full8);
    chk8("fullrd hi", 4'h1, 7);
    for (int i = 1; i < 8; i++) begin
      step8(0, 1, 8'h00);
      step8(0, 1, 8'h00);
    end
    chk8("drain2", 4'h1, 0);   // last entry 0x17, high nibble 1

    // ---- async reset mid-operation
    step8(1, 0, 8'h11);
    step8(1, 0, 8'h22);
    step8(1, 0, 8'h33);
    step8(0, 1, 8'h00);
    chk8("pre-rst", 4'h1, 3);
    #2 rst8 = 1'b1;
    #1;
    $display("async reset q0=%0h empty=%0b", q8[3:0], empty8);
    chk8("async rst", 4'h0, 0);
    @(posedge clk); #1;
    rst8 = 1'b0;
`ifdef OUT_FIFO_SYNC_ERRFLAG_EN
    chk("rst OVERFLOW",  64'(ovf8), 64'd0);
    chk("rst UNDERFLOW", 64'(unf8), 64'd0);
`endif
    step8(1, 0, 8'h9C);
    chk8("post-rst wr", 4'h0, 1);
    step8(0, 1, 8'h00);
    chk8("post-rst lo", 4'hC, 1);
    step8(0, 1, 8'h00);
    chk8("post-rst hi", 4'h9, 0);

    // ---- 4x4 mode
    step4(1, 0, 8'h3C);
    chk("4x4 wr1 EMPTY", 64'(empty4), 64'd0);
    step4(1, 0, 8'h7E);
    chk("4x4 wr2 ALMOSTEMPTY", 64'(aempty4), 64'd0);
    step4(0, 1, 8'h00);
    $display("4x4 rd1 q0=%0h empty=%0b", q4[3:0], empty4);
    chk("4x4 rd1 Q", 64'(q4), 64'({NUM_CH{4'hC}}));
    chk("4x4 rd1 EMPTY", 64'(empty4), 64'd0);
    chk("4x4 rd1 ALMOSTEMPTY", 64'(aempty4), 64'd1);
    step4(0, 1, 8'h00);
    $display("4x4 rd2 q0=%0h empty=%0b", q4[3:0], empty4);
    chk("4x4 rd2 Q", 64'(q4), 64'({NUM_CH{4'hE}}));
    chk("4x4 rd2 EMPTY", 64'(empty4), 64'd1);
`ifdef OUT_FIFO_SYNC_ERRFLAG_EN
    chk("4x4 UNDERFLOW clear", 64'(unf4), 64'd0);
    step4(0, 1, 8'h00);
    chk("4x4 UNDERFLOW set", 64'(unf4), 64'd1);
    step4(0, 0, 8'h00);
    chk("4x4 UNDERFLOW hold", 64'(unf4), 64'd1);
    chk("4x4 OVERFLOW clear", 64'(ovf4), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
